// File: rtl/diffusion_pkg.sv
// diffusion_pkg: shared types and GF(2^8) helpers for the AES diffusion layer.
// State indexing: [row][column][bit], port row r = AES row 3-r, port column c = AES column 3-c.
package diffusion_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    localparam logic [7:0] AES_POLY = 8'h1B;

    // Multiply by 2 in GF(2^8), reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by 3 in GF(2^8).
    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // AES row i rotated left by i bytes, expressed in port indexing.
    function automatic state_t shift_rows(input state_t s);
        state_t     r;
        logic [1:0] ri;
        logic [1:0] ci;
        logic [1:0] si;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ri = 2'(3 - i);
                ci = 2'(3 - j);
                si = 2'(3 - ((j + i) % 4));
                r[ri][ci] = s[ri][si];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/diffusion_mix_column.sv
// mix_column: combinational MixColumns on one AES column.
// col_in[3] is the top byte s0, col_in[0] the bottom byte s3; col_out uses the same order.
import diffusion_pkg::*;

module mix_column (
    input  logic [3:0][7:0] col_in,
    output logic [3:0][7:0] col_out
);

    logic [7:0] s0, s1, s2, s3;

    assign s0 = col_in[3];
    assign s1 = col_in[2];
    assign s2 = col_in[1];
    assign s3 = col_in[0];

    // Fixed circulant matrix {2,3,1,1} applied top to bottom.
    always_comb begin
        col_out    = '0;
        col_out[3] = xtime(s0) ^ gmul3(s1) ^ s2 ^ s3;
        col_out[2] = s0 ^ xtime(s1) ^ gmul3(s2) ^ s3;
        col_out[1] = s0 ^ s1 ^ xtime(s2) ^ gmul3(s3);
        col_out[0] = gmul3(s0) ^ s1 ^ s2 ^ xtime(s3);
    end

endmodule

// File: rtl/diffusion.sv
// diffusion: AES ShiftRows + MixColumns with a single output register stage.
// Optional macro DIFFUSION_SROWS_OUT_EN adds a registered ShiftRows-only output (srows_out).
// Handshake: in_valid high on a rising edge means diffusion_in is taken that edge; there is
// no ready/backpressure, a new state may arrive every cycle, and out_valid follows one cycle later.
import diffusion_pkg::*;

module diffusion (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_valid,
    input  state_t diffusion_in,
    output logic   out_valid,
    output state_t diffusion_out
`ifdef DIFFUSION_SROWS_OUT_EN
    ,
    output state_t srows_out
`endif
);

    state_t          sr;
    state_t          mc;
    logic [3:0][7:0] sr_col [4];
    logic [3:0][7:0] mc_col [4];

    assign sr = shift_rows(diffusion_in);

    // Split the shifted state into columns (row index kept as the byte index).
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            sr_col[c] = '0;
            for (int r = 0; r < 4; r++) begin
                sr_col[c][r] = sr[r][c];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_mix
        mix_column u_mix (
            .col_in  (sr_col[g]),
            .col_out (mc_col[g])
        );
    end

    // Reassemble the mixed columns into a full state.
    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mc[r][c] = mc_col[c][r];
            end
        end
    end

    // Output register: loads on in_valid, holds otherwise; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            diffusion_out <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diffusion_out <= mc;
            end
        end
    end

`ifdef DIFFUSION_SROWS_OUT_EN
    // ShiftRows intermediate, same enable and reset as diffusion_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            srows_out <= '0;
        end else if (in_valid) begin
            srows_out <= sr;
        end
    end
`endif

endmodule

// File: tb/tb_diffusion.sv
// tb_diffusion: directed vector table plus hand-written multi-cycle sequences for diffusion.
import diffusion_pkg::*;

module tb_diffusion;

    logic   clk;
    logic   reset;
    logic   in_valid;
    state_t diffusion_in;
    logic   out_valid;
    state_t diffusion_out;
`ifdef DIFFUSION_SROWS_OUT_EN
    state_t srows_out;
`endif

    int n_applied;
    int n_fail;

    typedef struct {
        string  name;
        state_t din;
        state_t exp_mix;
        state_t exp_sr;
    } vec_t;

    vec_t vecs[6];

    diffusion dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .diffusion_in  (diffusion_in),
        .out_valid     (out_valid),
        .diffusion_out (diffusion_out)
`ifdef DIFFUSION_SROWS_OUT_EN
        ,
        .srows_out     (srows_out)
`endif
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a state from AES rows 0..3, each written left to right.
    function automatic state_t rows4(input logic [31:0] r0, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] r3);
        state_t s;
        s[3] = r0;
        s[2] = r1;
        s[1] = r2;
        s[0] = r3;
        return s;
    endfunction

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input state_t act, input state_t exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    state_t zero_st;

    initial begin
        n_applied    = 0;
        n_fail       = 0;
        zero_st      = '0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        diffusion_in = '0;

        vecs[0].name    = "rows_01020304";
        vecs[0].din     = rows4(32'h01020304, 32'h01020304, 32'h01020304, 32'h01020304);
        vecs[0].exp_sr  = rows4(32'h01020304, 32'h02030401, 32'h03040102, 32'h04010203);
        vecs[0].exp_mix = rows4(32'h0304090a, 32'h04090a03, 32'h090a0304, 32'h0a030409);

        vecs[1].name    = "const_db135345";
        vecs[1].din     = rows4(32'hdbdbdbdb, 32'h13131313, 32'h53535353, 32'h45454545);
        vecs[1].exp_sr  = vecs[1].din;
        vecs[1].exp_mix = rows4(32'h8e8e8e8e, 32'h4d4d4d4d, 32'ha1a1a1a1, 32'hbcbcbcbc);

        vecs[2].name    = "const_d4bf5d30";
        vecs[2].din     = rows4(32'hd4d4d4d4, 32'hbfbfbfbf, 32'h5d5d5d5d, 32'h30303030);
        vecs[2].exp_sr  = vecs[2].din;
        vecs[2].exp_mix = rows4(32'h04040404, 32'h66666666, 32'h81818181, 32'he5e5e5e5);

        vecs[3].name    = "fips_round1";
        vecs[3].din     = rows4(32'hd4e0b81e, 32'h27bfb441, 32'h11985d52, 32'haef1e530);
        vecs[3].exp_sr  = rows4(32'hd4e0b81e, 32'hbfb44127, 32'h5d521198, 32'h30aef1e5);
        vecs[3].exp_mix = rows4(32'h04e04828, 32'h66cbf806, 32'h8119d326, 32'he59a7a4c);

        vecs[4].name    = "all_01";
        vecs[4].din     = {16{8'h01}};
        vecs[4].exp_sr  = {16{8'h01}};
        vecs[4].exp_mix = {16{8'h01}};

        vecs[5].name    = "all_00";
        vecs[5].din     = '0;
        vecs[5].exp_sr  = '0;
        vecs[5].exp_mix = '0;

        // Reset dominates in_valid with non-zero data present.
        in_valid     = 1'b1;
        diffusion_in = vecs[3].din;
        step();
        step();
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_state("reset_diffusion_out", diffusion_out, zero_st);
`ifdef DIFFUSION_SROWS_OUT_EN
        check_state("reset_srows_out", srows_out, zero_st);
`endif
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        check_bit("idle_out_valid", out_valid, 1'b0);

        // Table: one-cycle pulses with an idle cycle between them.
        for (int i = 0; i < 6; i++) begin
            in_valid     = 1'b1;
            diffusion_in = vecs[i].din;
            step();
            in_valid     = 1'b0;
            diffusion_in = '0;
            check_bit({vecs[i].name, "_valid"}, out_valid, 1'b1);
            check_state({vecs[i].name, "_mix"}, diffusion_out, vecs[i].exp_mix);
`ifdef DIFFUSION_SROWS_OUT_EN
            check_state({vecs[i].name, "_srows"}, srows_out, vecs[i].exp_sr);
`endif
            step();
            check_bit({vecs[i].name, "_drop"}, out_valid, 1'b0);
            check_state({vecs[i].name, "_hold"}, diffusion_out, vecs[i].exp_mix);
        end

        // Back-to-back: three states on consecutive cycles.
        in_valid     = 1'b1;
        diffusion_in = vecs[0].din;
        step();
        check_bit("b2b0_valid", out_valid, 1'b1);
        check_state("b2b0_mix", diffusion_out, vecs[0].exp_mix);
        diffusion_in = vecs[3].din;
        step();
        check_bit("b2b1_valid", out_valid, 1'b1);
        check_state("b2b1_mix", diffusion_out, vecs[3].exp_mix);
        diffusion_in = vecs[2].din;
        step();
        check_bit("b2b2_valid", out_valid, 1'b1);
        check_state("b2b2_mix", diffusion_out, vecs[2].exp_mix);
        in_valid     = 1'b0;
        diffusion_in = vecs[1].din;
        step();
        check_bit("b2b_drop", out_valid, 1'b0);
        check_state("b2b_hold", diffusion_out, vecs[2].exp_mix);
        step();
        check_state("b2b_hold2", diffusion_out, vecs[2].exp_mix);

        // Mid-stream reset discards the in-flight state.
        in_valid     = 1'b1;
        diffusion_in = vecs[1].din;
        reset        = 1'b1;
        step();
        check_bit("midrst_valid", out_valid, 1'b0);
        check_state("midrst_mix", diffusion_out, zero_st);
`ifdef DIFFUSION_SROWS_OUT_EN
        check_state("midrst_srows", srows_out, zero_st);
`endif
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check_bit("postrst_valid", out_valid, 1'b0);
        check_state("postrst_mix", diffusion_out, zero_st);

        // First valid output after reset needs a fresh in_valid.
        in_valid     = 1'b1;
        diffusion_in = vecs[1].din;
        step();
        in_valid = 1'b0;
        check_bit("postrst_new_valid", out_valid, 1'b1);
        check_state("postrst_new_mix", diffusion_out, vecs[1].exp_mix);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
